// File: rtl/ws281x_bit_encoder.sv
`default_nettype none
// ============================================================================
// Module      : ws281x_bit_encoder
// Description : WS281x serial line waveform generator. Takes one bit (or a
//               frame latch request) per valid/ready handshake and drives the
//               LED line high then low with bit-dependent lengths, or low for
//               the latch period. Back-to-back requests chain without a gap.
//               Optional macro WS281X_ENCODER_INVERT_EN inverts the line
//               output for inverting level shifters.
// Revision    : 1.0 - initial release
// ============================================================================
module ws281x_bit_encoder #(
  parameter int UNIT_CLKS = 2,
  parameter int RST_UNITS = 6000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       bit_vld_in,
  input  logic       bit_data_in,
  input  logic       frame_end_in,
  input  logic [7:0] t0h_cnt_in,
  input  logic [7:0] t0l_cnt_in,
  input  logic [7:0] t1h_cnt_in,
  input  logic [7:0] t1l_cnt_in,
  output logic       bit_rdy_out,
  output logic       busy_out,
  output logic       bit_code_out
);

  // The prescaler needs at least one bit even when UNIT_CLKS is 1.
  localparam int              PRE_W    = (UNIT_CLKS > 1) ? $clog2(UNIT_CLKS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(UNIT_CLKS - 1);
  localparam logic [15:0]      RST_LEN  = 16'(RST_UNITS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HIGH  = 2'd1;
  localparam logic [1:0] LOW   = 2'd2;
  localparam logic [1:0] LATCH = 2'd3;

  logic [1:0]       state;
  logic [PRE_W-1:0] pre;
  logic [15:0]      unit_cnt;
  logic [7:0]       high_len;
  logic [7:0]       low_len;

  logic [15:0] phase_len;
  logic        phase_last;
  logic        accept;
  logic        take_bit;
  logic [7:0]  high_sel;
  logic [7:0]  low_sel;
  logic        wave_high;

  // Length in units of whichever phase is currently running.
  always_comb begin
    phase_len = 16'd1;
    case (state)
      HIGH:    phase_len = {8'd0, high_len};
      LOW:     phase_len = {8'd0, low_len};
      LATCH:   phase_len = RST_LEN;
      default: phase_len = 16'd1;
    endcase
  end

  // Final clock of the running phase: terminal prescaler and unit counts.
  assign phase_last = (state != IDLE) && (pre == PRE_LAST) &&
                      (unit_cnt == (phase_len - 16'd1));

  assign bit_rdy_out = (state == IDLE) ||
                       (phase_last && ((state == LOW) || (state == LATCH)));
  assign accept      = bit_rdy_out && (bit_vld_in || frame_end_in);
  assign take_bit    = accept && bit_vld_in;
  assign busy_out    = (state != IDLE);

  // Zero counts are clamped to one unit so no phase can vanish.
  assign high_sel = bit_data_in ? t1h_cnt_in : t0h_cnt_in;
  assign low_sel  = bit_data_in ? t1l_cnt_in : t0l_cnt_in;

  // Phase sequencing, timing capture and shared prescaler/unit counter.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      pre      <= '0;
      unit_cnt <= 16'd0;
      high_len <= 8'd0;
      low_len  <= 8'd0;
    end else if (accept) begin
      state    <= take_bit ? HIGH : LATCH;
      pre      <= '0;
      unit_cnt <= 16'd0;
      if (take_bit) begin
        high_len <= (high_sel == 8'd0) ? 8'd1 : high_sel;
        low_len  <= (low_sel  == 8'd0) ? 8'd1 : low_sel;
      end
    end else if (phase_last) begin
      state    <= (state == HIGH) ? LOW : IDLE;
      pre      <= '0;
      unit_cnt <= 16'd0;
    end else if (state != IDLE) begin
      if (pre == PRE_LAST) begin
        pre      <= '0;
        unit_cnt <= unit_cnt + 16'd1;
      end else begin
        pre <= pre + PRE_W'(1);
      end
    end
  end

  // Line is driven straight from state so reset forces it idle at once.
  assign wave_high = (state == HIGH);

`ifdef WS281X_ENCODER_INVERT_EN
  assign bit_code_out = ~wave_high;
`else
  assign bit_code_out = wave_high;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ws281x_bit_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ws281x_bit_encoder
// Description : Scoreboard bench for ws281x_bit_encoder. The driver pushes the
//               expected per-clock line/busy/ready trace for each accepted
//               request; a monitor pops and compares every clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ws281x_bit_encoder;

  localparam int UNIT = 2;
  localparam int RSTU = 6000;
`ifdef WS281X_ENCODER_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_vld = 1'b0;
  logic       bit_data = 1'b0;
  logic       frame_end = 1'b0;
  logic [7:0] t0h = 8'd0, t0l = 8'd0, t1h = 8'd0, t1l = 8'd0;
  logic       bit_rdy, busy, bit_code;

  int  checks = 0;
  int  failures = 0;
  bit  mon_en = 1'b0;
  logic [2:0] exp_q[$];   // {line, busy, ready} per clock

  ws281x_bit_encoder #(.UNIT_CLKS(UNIT), .RST_UNITS(RSTU)) dut (
    .clk_in(clk), .rst_in(rst), .bit_vld_in(bit_vld), .bit_data_in(bit_data),
    .frame_end_in(frame_end), .t0h_cnt_in(t0h), .t0l_cnt_in(t0l),
    .t1h_cnt_in(t1h), .t1l_cnt_in(t1l), .bit_rdy_out(bit_rdy),
    .busy_out(busy), .bit_code_out(bit_code)
  );

  always #5 clk = ~clk;

  // Reference waveform: high h units, low l units (0 counts as 1).
  task automatic push_bit(input logic [7:0] h, input logic [7:0] l);
    int hc = ((h == 0) ? 1 : int'(h)) * UNIT;
    int lc = ((l == 0) ? 1 : int'(l)) * UNIT;
    for (int i = 0; i < hc; i++) exp_q.push_back({~INV, 1'b1, 1'b0});
    for (int i = 0; i < lc; i++) exp_q.push_back({INV, 1'b1, (i == lc - 1)});
  endtask

  task automatic push_latch();
    int n = RSTU * UNIT;
    for (int i = 0; i < n; i++) exp_q.push_back({INV, 1'b1, (i == n - 1)});
  endtask

  // Monitor: each clock compare DUT against the next expected entry;
  // an empty queue means the encoder must be idle and ready.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [2:0] e;
      logic [2:0] a;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : {INV, 1'b0, 1'b1};
      a = {bit_code, busy, bit_rdy};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle_trace t=%0t actual line/busy/rdy=%b%b%b required=%b%b%b",
                 $time, a[2], a[1], a[0], e[2], e[1], e[0]);
      end
    end
  end

  // Wait for the handshake; returns at posedge+1 after the accepting edge.
  task automatic wait_accept();
    int n = 0;
    forever begin
      @(negedge clk); #1;
      if (bit_rdy) begin
        @(posedge clk); #1;
        return;
      end
      n++;
      if (n > 20000) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=no_ready required=ready_within_20000");
        return;
      end
    end
  endtask

  task automatic issue_bit(input logic d, input logic [7:0] h0, input logic [7:0] l0,
                           input logic [7:0] h1, input logic [7:0] l1,
                           input logic with_frame);
    bit_vld = 1'b1; bit_data = d; frame_end = with_frame;
    t0h = h0; t0l = l0; t1h = h1; t1l = l1;
    wait_accept();
    push_bit(d ? h1 : h0, d ? l1 : l0);
    if (with_frame) begin
      bit_vld = 1'b0;
      wait_accept();
      push_latch();
      frame_end = 1'b0;
    end
  endtask

  task automatic go_idle(input int n);
    bit_vld = 1'b0; frame_end = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [7:0] rnd_cnt();
    int k = $urandom_range(0, 15);
    if (k == 0) return 8'd0;
    if (k == 1) return 8'd255;
    if (k == 2) return 8'($urandom_range(100, 254));
    return 8'($urandom_range(1, 6));
  endfunction

  initial begin
    // Reset with a request held: nothing may be accepted.
    bit_vld = 1'b1; bit_data = 1'b1; t1h = 8'd3; t1l = 8'd3;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({bit_code, busy, bit_rdy} !== {INV, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL reset_state actual=%b%b%b required=%b01", bit_code, busy, bit_rdy, INV);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; bit_vld = 1'b0;
    mon_en = 1'b1;
    go_idle(3);

    // Bit 0 with t0h=1, t0l=0x7f.
    issue_bit(1'b0, 8'd1, 8'h7f, 8'd9, 8'd9, 1'b0);
    go_idle(2);
    // Two bit 1s back to back with 0xfe / 0x01.
    issue_bit(1'b1, 8'd4, 8'd4, 8'hfe, 8'h01, 1'b0);
    issue_bit(1'b1, 8'd4, 8'd4, 8'hfe, 8'h01, 1'b0);
    // Zero high count clamped; counts change while this bit is in flight.
    issue_bit(1'b0, 8'd0, 8'd5, 8'd2, 8'd2, 1'b0);
    issue_bit(1'b0, 8'd3, 8'd40, 8'd1, 8'd1, 1'b0);
    go_idle(1);
    // Bit and latch together, then a bit chained off the latch end.
    issue_bit(1'b1, 8'd2, 8'd2, 8'd3, 8'd0, 1'b1);
    issue_bit(1'b0, 8'd2, 8'd0, 8'd3, 8'd3, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 5) == 0) go_idle($urandom_range(0, 3));
      issue_bit(1'($urandom_range(0, 1)), rnd_cnt(), rnd_cnt(), rnd_cnt(), rnd_cnt(), 1'b0);
    end
    go_idle(1);
    begin
      int n = 0;
      while (exp_q.size() > 0 && n < 5000) begin @(posedge clk); n++; end
    end
    go_idle(3);

    // Asynchronous reset in the middle of a high phase.
    issue_bit(1'b1, 8'd1, 8'd1, 8'd20, 8'd5, 1'b0);
    bit_vld = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (bit_code !== ~INV) begin
      failures++;
      $display("FAIL pre_reset_high actual=%b required=%b", bit_code, ~INV);
    end
    mon_en = 1'b0;
    exp_q.delete();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bit_code, busy, bit_rdy} !== {INV, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL async_reset actual=%b%b%b required=%b01", bit_code, busy, bit_rdy, INV);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    go_idle(2);
    issue_bit(1'b0, 8'd2, 8'd3, 8'd1, 8'd1, 1'b0);
    go_idle(1);
    begin
      int n = 0;
      while (exp_q.size() > 0 && n < 5000) begin @(posedge clk); n++; end
    end
    go_idle(3);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
